// File: rtl/load_stream_ctrl.sv
// Load/stream sequencer: reads an N-element x/w vector into the MAC array,
// then waits for the MAC pipeline to drain before reporting completion.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no load in progress, waiting for start
// ST_STREAM | issuing reads k = 0..N-1, stalling while src_ready is low
// ST_DRAIN  | last read issued, waiting for mac_last plus DRAIN pipeline cycles
module load_stream_ctrl #(
  parameter int N     = 4,
  parameter int DRAIN = 2,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [2:0]    acc_sel_in,
  input  logic          src_ready,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          mac_valid,
  output logic          mac_first,
  output logic          mac_last,
  output logic [2:0]    acc_sel,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(N - 1);
  localparam int            DW         = (DRAIN > 1) ? $clog2(DRAIN + 1) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = (DRAIN > 0) ? DW'(DRAIN - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } state_t;

  state_t        state;
  logic [AW-1:0] k;
  logic [AW-1:0] cur_k;
  logic [DW-1:0] drain_cnt;
  logic          last_seen;
  logic          stream_step;

  // The accepting edge already issues read 0, so the index restarts from 0 there.
  assign cur_k       = (state == ST_IDLE) ? '0 : k;
  assign stream_step = (state == ST_STREAM) || ((state == ST_IDLE) && start);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      k         <= '0;
      drain_cnt <= '0;
      last_seen <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      mac_valid <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
      acc_sel   <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      mac_valid <= rd_en;
      mac_first <= rd_en && (rd_addr == '0);
      mac_last  <= rd_en && (rd_addr == LAST_ADDR);

      if (abort) begin
        state     <= ST_IDLE;
        last_seen <= 1'b0;
        rd_en     <= 1'b0;
        mac_valid <= 1'b0;
        mac_first <= 1'b0;
        mac_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        rd_en <= 1'b0;
        if (stream_step) begin
          if (state == ST_IDLE) begin
            state     <= ST_STREAM;
            acc_sel   <= acc_sel_in;
            busy      <= 1'b1;
            k         <= '0;
            last_seen <= 1'b0;
            drain_cnt <= '0;
          end
          rd_en <= src_ready;
          if (src_ready) begin
            rd_addr <= cur_k;
            k       <= cur_k + AW'(1);
            if (cur_k == LAST_ADDR) begin
              state <= ST_DRAIN;
            end
          end
        end else if (state == ST_DRAIN) begin
          // mac_last is one cycle behind the last read; count DRAIN cycles after it.
          if (!last_seen) begin
            if (mac_last) begin
              if (DRAIN == 0) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                last_seen <= 1'b1;
                drain_cnt <= DRAIN_LOAD;
              end
            end
          end else if (drain_cnt == '0) begin
            state     <= ST_IDLE;
            last_seen <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
      end
    end
  end

endmodule

// File: doc/load_stream_ctrl.md
LOAD_STREAM_CTRL -- requirements
Module: load_stream_ctrl

Interface
REQ-001 SHALL have parameter N, default 4, giving the vector length streamed per load (N >= 1).
REQ-002 SHALL have parameter DRAIN, default 2, giving the MAC pipeline drain cycles after the last valid element (DRAIN >= 0).
REQ-003 SHALL have parameter AW, default 2, giving the address width, with 2^AW >= N.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port start  input  1  load request pulse from the top sequencer.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current load.
REQ-008 SHALL have port acc_sel_in  input  3  accumulator select, sampled with start.
REQ-009 SHALL have port src_ready  input  1  x/w source can accept a read this cycle.
REQ-010 SHALL have port rd_en  output  1  read strobe to the x/w buffers.
REQ-011 SHALL have port rd_addr  output  AW  element index k of the current read.
REQ-012 SHALL have port mac_valid  output  1  element valid at the MAC inputs (rd_en delayed 1 cycle).
REQ-013 SHALL have port mac_first  output  1  qualifies mac_valid for element 0 (accumulator clear/overwrite).
REQ-014 SHALL have port mac_last  output  1  qualifies mac_valid for element N-1.
REQ-015 SHALL have port acc_sel  output  3  latched accumulator select driven to the MACs.
REQ-016 SHALL have port busy  output  1  load in progress.
REQ-017 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, STREAM and DRAIN, with all outputs registered.
REQ-019 IDLE: on an edge where start=1 (and abort=0), SHALL enter STREAM, latch acc_sel<=acc_sel_in, set busy<=1, and set the element counter to 0.
REQ-020 SHALL ignore start while busy=1, with no effect on the counter, acc_sel or the state.
REQ-021 STREAM: at each edge, rd_en<=src_ready; if src_ready=1, rd_addr<=k and k<=k+1, otherwise rd_addr and k hold. This rule includes the edge that enters STREAM.
REQ-022 SHALL issue exactly N reads per load, with addresses 0..N-1 in order and without gaps in address.
REQ-023 SHALL enter DRAIN on the edge that issues read k=N-1; rd_en SHALL be 0 from the following edge.
REQ-024 SHALL produce mac_valid, mac_first and mac_last as rd_en, (rd_en & addr==0) and (rd_en & addr==N-1), each delayed by exactly one cycle.
REQ-025 For N=1, mac_first and mac_last SHALL assert in the same cycle.
REQ-026 DRAIN SHALL wait until mac_last has been high, then DRAIN further cycles; on the next edge busy<=0, done<=1 and the state returns to IDLE.
REQ-027 With src_ready held high, busy SHALL be high for exactly N+1+DRAIN cycles, and done SHALL coincide with the first cycle of busy=0.
REQ-028 done SHALL be high for exactly one cycle per completed load and never for an aborted load.
REQ-029 abort=1 at any edge in STREAM or DRAIN SHALL return to IDLE and clear rd_en, mac_valid, mac_first, mac_last and busy, with done=0.
REQ-030 If abort=1 and start=1 occur at the same edge in IDLE, abort SHALL win and the block SHALL stay in IDLE.
REQ-031 acc_sel SHALL hold its latched value until the next accepted start, including while in IDLE.
REQ-032 start arriving on the same edge that done is asserted SHALL be ignored, because busy is still 1 at that edge; it is accepted on any later edge.

Reset
REQ-033 rst=1 SHALL immediately force IDLE, with rd_en, rd_addr, mac_valid, mac_first, mac_last, acc_sel, busy, done and the counters all 0, independent of clk.
REQ-034 Reset asserted mid-load SHALL discard the load and produce no done pulse after release.
REQ-035 After rst deasserts, the first accepted start SHALL behave identically to a start issued after power-up.

Verification
REQ-036 Scenario (N=4, DRAIN=2, src_ready=1): start with acc_sel_in=3 at E0 -> rd_en at E0..E3 with addr 0,1,2,3; mac_valid at E1..E4; mac_first at E1; mac_last at E4; acc_sel=3; busy for 7 cycles; done at E7.
REQ-037 Scenario: src_ready low for 2 cycles after addr 1 -> rd_en gap of 2 cycles, addr holds at 1, addresses still 0..3 with none skipped or repeated, done delayed by exactly 2 cycles.
REQ-038 Scenario: start re-pulsed at E2 and at the done edge -> both ignored; the next start one cycle after done starts a fresh load with addr 0.
REQ-039 Scenario: abort at E2 -> IDLE from E3 with all strobes 0, no done; a following start runs a full 4-element load.
REQ-040 Scenario: rst asserted asynchronously mid-DRAIN -> all outputs 0 before the next edge, no done after release.
REQ-041 Scenario (N=1, DRAIN=0): start at E0 -> mac_first=mac_last=mac_valid at E1, done at E2, busy for 2 cycles.
